// File: rtl/run_pack.sv
// Shared types and defaults for the CPU run sequencer.
// Imported by cpu_run_ctrl and its sub-blocks.
package run_pack;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } run_state_t;

  localparam int unsigned START_CYC_DEF = 2;
  localparam int unsigned MAX_CYC_DEF   = 2 ** 20;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached; at_max flags that.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         at_max
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Clear wins over count; stop counting at all-ones.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en && !(&q_q)) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign at_max = &q_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run sequencer: launches the CPU, counts RUN cycles
// until done or watchdog, reports via valid/ack.
module cpu_run_ctrl
  import run_pack::*;
#(
  parameter int unsigned CW        = 32,
  parameter int unsigned START_CYC = START_CYC_DEF,
  parameter int unsigned MAX_CYC   = MAX_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_req,
  input  logic [1:0]    host_prog,
  output logic          host_busy,
  output logic          host_valid,
  input  logic          host_ack,
  output logic [CW-1:0] cycles,
  output logic          timeout,
  output logic          cpu_start,
  output logic [1:0]    cpu_prog_sel,
  input  logic          cpu_done
);

  localparam int unsigned SW =
    (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [SW-1:0] ST_LAST = SW'(START_CYC - 1);
  localparam logic [CW-1:0] MAX_V   = CW'(MAX_CYC);

  run_state_t    state_q, state_d;
  logic [SW-1:0] st_cnt_q, st_cnt_d;
  logic [1:0]    prog_q, prog_d;
  logic          to_q, to_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;

  logic          cnt_clr;
  logic          cnt_en;
  logic [CW-1:0] cnt_q;
  logic          cnt_max;
  logic [CW-1:0] cnt_inc;

  sat_counter #(
    .W(CW)
  ) u_cyc_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .q      (cnt_q),
    .at_max (cnt_max)
  );

  // Value the counter takes this RUN cycle.
  assign cnt_inc = cnt_max ? cnt_q : cnt_q + CW'(1);

  // Next state; status flops follow state_d so
  // every output comes straight from a register.
  always_comb begin
    state_d  = state_q;
    st_cnt_d = st_cnt_q;
    prog_d   = prog_q;
    to_d     = to_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (host_req) begin
          prog_d   = host_prog;
          to_d     = 1'b0;
          cnt_clr  = 1'b1;
          st_cnt_d = '0;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        if (st_cnt_q == ST_LAST) begin
          state_d = RUN;
        end else begin
          st_cnt_d = st_cnt_q + SW'(1);
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        if (cpu_done) begin
          to_d    = 1'b0;
          state_d = REPORT;
        end else if (cnt_inc == MAX_V) begin
          to_d    = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (host_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    start_d = (state_d != RUN);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == REPORT);
  end

  // State and registered outputs; CPU held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      st_cnt_q <= '0;
      prog_q   <= 2'd0;
      to_q     <= 1'b0;
      start_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      st_cnt_q <= st_cnt_d;
      prog_q   <= prog_d;
      to_q     <= to_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign host_busy    = busy_q;
  assign host_valid   = valid_q;
  assign cycles       = cnt_q;
  assign timeout      = to_q;
  assign cpu_start    = start_q;
  assign cpu_prog_sel = prog_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl with a
// simple CPU model raising done after N RUN cycles.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        host_req = 1'b0;
  logic [1:0]  host_prog = 2'd0;
  logic        host_ack = 1'b0;
  logic        cpu_done = 1'b0;
  logic        host_busy;
  logic        host_valid;
  logic [31:0] cycles;
  logic        timeout;
  logic        cpu_start;
  logic [1:0]  cpu_prog_sel;

  cpu_run_ctrl #(
    .CW        (32),
    .START_CYC (2),
    .MAX_CYC   (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_req     (host_req),
    .host_prog    (host_prog),
    .host_busy    (host_busy),
    .host_valid   (host_valid),
    .host_ack     (host_ack),
    .cycles       (cycles),
    .timeout      (timeout),
    .cpu_start    (cpu_start),
    .cpu_prog_sel (cpu_prog_sel),
    .cpu_done     (cpu_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cyc;
    logic        to;
    logic [1:0]  prog;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errs = 0;
  int   checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // CPU model: done once RUN cycle count reaches done_at.
  int run_cnt = 0;
  int done_at = 0;
  always @(negedge clk) begin
    if (cpu_start !== 1'b0) run_cnt = 0;
    else run_cnt++;
    cpu_done = (done_at != 0) && (cpu_start === 1'b0)
               && (run_cnt >= done_at);
  end

  // Monitor: pop and compare on each new valid.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (host_valid === 1'b1 && !prev_v) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_valid: got 1 expected 0");
      end else begin
        mon_e = sb.pop_front();
        chk("sb_cycles", cycles, mon_e.cyc);
        chk("sb_timeout", 32'(timeout), 32'(mon_e.to));
        chk("sb_prog", 32'(cpu_prog_sel), 32'(mon_e.prog));
      end
    end
    prev_v = (host_valid === 1'b1);
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"}, 32'(cpu_start), 32'd1);
    chk({tag, "_busy"}, 32'(host_busy), 32'd0);
    chk({tag, "_valid"}, 32'(host_valid), 32'd0);
    chk({tag, "_cycles"}, cycles, 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_prog"}, 32'(cpu_prog_sel), 32'd0);
  endtask

  task automatic do_run(input logic [1:0] prog,
                        input int d_at,
                        input logic [31:0] ecyc,
                        input logic eto,
                        input bit poke,
                        input int hold);
    int n;
    bit bad;
    logic [31:0] cs;
    logic ts;
    done_at = d_at;
    sb.push_back('{ecyc, eto, prog});
    host_prog = prog;
    host_req = 1'b1;
    @(negedge clk);
    host_req = 1'b0;
    chk("busy_launch", 32'(host_busy), 32'd1);
    chk("prog_capture", 32'(cpu_prog_sel), 32'(prog));
    chk("cyc_clear", cycles, 32'd0);
    n = 1;
    while (cpu_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("start_width", 32'(n - 1), 32'd2);
    n = 0;
    while (!host_valid && n < 1000) begin
      if (poke && n == 3) begin
        host_req = 1'b1;
        host_prog = ~prog;
      end else if (poke && n == 4) begin
        host_req = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    if (!host_valid) begin
      checks++;
      errs++;
      $display("FAIL valid_wait: got 0 expected 1");
    end
    chk("prog_hold", 32'(cpu_prog_sel), 32'(prog));
    host_prog = prog;
    cs = cycles;
    ts = timeout;
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (cycles !== cs || timeout !== ts ||
          cpu_start !== 1'b1 || host_valid !== 1'b1)
        bad = 1'b1;
    end
    if (hold > 0) chk("report_stable", 32'(bad), 32'd0);
    host_ack = 1'b1;
    if (poke) host_req = 1'b1;
    @(negedge clk);
    host_ack = 1'b0;
    host_req = 1'b0;
    chk("valid_drop", 32'(host_valid), 32'd0);
    chk("busy_idle", 32'(host_busy), 32'd0);
    @(negedge clk);
    chk("req_not_queued", 32'(host_busy), 32'd0);
  endtask

  initial begin
    int n;
    #12;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_run(2'd2, 10, 32'd10, 1'b0, 1'b0, 0);
    do_run(2'd1, 0, 32'd16, 1'b1, 1'b0, 0);
    do_run(2'd3, 16, 32'd16, 1'b0, 1'b0, 0);
    do_run(2'd0, 10, 32'd10, 1'b0, 1'b1, 0);
    do_run(2'd2, 0, 32'd16, 1'b1, 1'b0, 50);

    done_at = 0;
    host_prog = 2'd3;
    host_req = 1'b1;
    @(negedge clk);
    host_req = 1'b0;
    n = 0;
    while (cpu_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_in_run", 32'(cpu_start), 32'd0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrun");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_valid_after_abort", 32'(host_valid), 32'd0);
    do_run(2'd1, 5, 32'd5, 1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
